// File: rtl/mmio_uart_responder.sv
// ---------------------------------------------------------------------------
// mmio_uart_responder
//
// Memory-mapped UART peripheral for the MEMbus peripheral strobe interface.
// A CPU write access pushes one byte into the TX FIFO. A CPU read access
// returns a status/data word and pops the RX FIFO. An 8N1 serialiser drives
// TX and an 8N1 deserialiser samples RX.
//
// Ports:
//   CLK      in   1  system clock
//   RST      in   1  synchronous active-high reset
//   sel      in   1  peripheral select; may stay high for several cycles
//   write    in   1  access is a write (only meaningful while sel=1)
//   dataIn   in   8  write data byte
//   dataOut  out 16  {2'b0, txOvf, frameErr, rxOvr, txIdle, txFull,
//                     rxValid, rxHead}
//   RX       in   1  serial in, asynchronous, idle high
//   TX       out  1  serial out, registered, idle high
//
// Build option:
//   UART_LOOPBACK_EN  when defined, the deserialiser listens to the internal
//                     TX register instead of the RX pin.
// ---------------------------------------------------------------------------
module mmio_uart_responder #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sel,
  input  logic        write,
  input  logic [7:0]  dataIn,
  output logic [15:0] dataOut,
  input  logic        RX,
  output logic        TX
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int CW    = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // -------------------------------------------------------------------------
  // Access edge detect: a new access begins when sel rises, or when write
  // flips while sel stays high. Only that first cycle pushes or pops.
  // -------------------------------------------------------------------------
  logic sel_q;
  logic write_q;
  logic acc_start;
  logic cpu_push;
  logic cpu_read;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      sel_q   <= sel;
      write_q <= write;
    end
  end

  assign acc_start = sel && (!sel_q || (write_q != write));
  assign cpu_push  = acc_start && write;
  assign cpu_read  = acc_start && !write;

  // -------------------------------------------------------------------------
  // TX FIFO. Pointers carry one extra bit to tell full from empty.
  // -------------------------------------------------------------------------
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TX_AW:0] tx_wptr_q;
  logic [TX_AW:0] tx_rptr_q;
  logic           tx_empty;
  logic           tx_full;
  logic           tx_push;
  logic           tx_pop;
  logic           tx_ovf_set;
  logic [7:0]     tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                    (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
  assign tx_head  = tx_mem_q[tx_rptr_q[TX_AW-1:0]];

  // A serialiser pop in the same cycle frees the slot the CPU byte lands in.
  assign tx_push    = cpu_push && (!tx_full || tx_pop);
  assign tx_ovf_set = cpu_push && tx_full && !tx_pop;

  always_ff @(posedge CLK) begin
    if (tx_push) begin
      tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= dataIn;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // TX serialiser. tx_d is computed from the state being entered so that the
  // pin changes on the same edge as the state.
  // -------------------------------------------------------------------------
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]    tx_bit_q,   tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q,       tx_d;
  logic          tx_idle;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_d       = 1'b0;
            tx_state_d = ST_START;
          end else begin
            tx_d       = 1'b1;
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign TX      = tx_q;
  assign tx_idle = tx_empty && (tx_state_q == ST_IDLE);

  // -------------------------------------------------------------------------
  // RX input selection
  // -------------------------------------------------------------------------
  logic rx_in;

`ifdef UART_LOOPBACK_EN
  // tx_q is already a register in this clock domain, so no synchroniser.
  logic unused_rx_pin;
  assign unused_rx_pin = RX;
  assign rx_in         = tx_q;
`else
  logic rx_meta_q;
  logic rx_sync_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_in = rx_sync_q;
`endif

  // -------------------------------------------------------------------------
  // RX deserialiser. The start bit is re-checked at mid-bit; every later
  // sample therefore lands near the centre of its bit.
  // -------------------------------------------------------------------------
  logic          rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_bit_q,   rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_byte_done;
  logic          frame_err_set;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_done  = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_in) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_in) begin
            rx_bit_d   = '0;
            rx_state_d = ST_DATA;
          end else begin
            rx_state_d = ST_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_in) begin
            rx_byte_done = 1'b1;
          end else begin
            frame_err_set = 1'b1;
          end
          // Back to IDLE at mid-stop so a following start edge is not missed.
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_prev_q  <= rx_in;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // -------------------------------------------------------------------------
  // RX FIFO
  // -------------------------------------------------------------------------
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RX_AW:0] rx_wptr_q;
  logic [RX_AW:0] rx_rptr_q;
  logic           rx_empty;
  logic           rx_full;
  logic           rx_push;
  logic           rx_pop;
  logic           rx_ovr_set;
  logic [7:0]     rx_head;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                    (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q[RX_AW-1:0]];

  // A CPU pop in the same cycle makes room, so the new byte is kept.
  assign rx_pop     = cpu_read && !rx_empty;
  assign rx_push    = rx_byte_done && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_byte_done && rx_full && !rx_pop;

  always_ff @(posedge CLK) begin
    if (rx_push) begin
      rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_shift_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky flags: a read access clears them, but an event arriving in the
  // same cycle as the clear is still recorded.
  // -------------------------------------------------------------------------
  logic rx_ovr_q;
  logic frame_err_q;
  logic tx_ovf_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      if (cpu_read) begin
        rx_ovr_q    <= 1'b0;
        frame_err_q <= 1'b0;
        tx_ovf_q    <= 1'b0;
      end
      if (rx_ovr_set)    rx_ovr_q    <= 1'b1;
      if (frame_err_set) frame_err_q <= 1'b1;
      if (tx_ovf_set)    tx_ovf_q    <= 1'b1;
    end
  end

  // Purely from registers, so the CPU sees the pre-pop word during a read.
  assign dataOut = {2'b00, tx_ovf_q, frame_err_q, rx_ovr_q, tx_idle, tx_full,
                    !rx_empty, rx_head};

endmodule

// File: tb/tb_mmio_uart_responder.sv
`timescale 1ns/1ps
module tb_mmio_uart_responder;

  localparam int CPB  = 104;
  localparam int HALF = CPB / 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sel = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  dataIn = 8'h00;
  logic [15:0] dataOut;
  logic        RX = 1'b1;
  logic        TX;

  int checks = 0;
  int failures = 0;

  mmio_uart_responder #(
    .CLKS_PER_BIT(CPB),
    .TX_DEPTH(8),
    .RX_DEPTH(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .sel(sel),
    .write(write),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .RX(RX),
    .TX(TX)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit hit, got no summary expected TB_RESULT");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; sel = 1'b0; write = 1'b0; RX = 1'b1;
    step(3);
    RST = 1'b0;
    step(1);
  endtask

  task automatic cpu_write(input logic [7:0] b, input int hold);
    sel = 1'b1; write = 1'b1; dataIn = b;
    step(hold);
    sel = 1'b0; write = 1'b0;
    step(1);
    $display("wr %02h hold=%0d", b, hold);
  endtask

  task automatic cpu_read(output logic [15:0] w);
    sel = 1'b1; write = 1'b0;
    w = dataOut;
    step(1);
    sel = 1'b0;
    step(1);
    $display("rd %04h", w);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      step(CPB);
    end
    RX = stop_bit;
    step(CPB);
    RX = 1'b1;
    $display("rx frame %02h stop=%0b", b, stop_bit);
  endtask

  // Samples a TX frame at mid-bit. When contiguous, the caller sits at the
  // middle of the previous stop bit and the next start bit must follow it.
  task automatic expect_tx(input logic [7:0] exp, input bit contiguous, input string tag);
    logic [7:0] got;
    int waited;
    if (contiguous) begin
      step(HALF);
      check({tag, " no-gap start"}, TX, 1'b0);
    end else begin
      waited = 0;
      while (TX !== 1'b0 && waited < 3000) begin
        step(1);
        waited++;
      end
      if (TX !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: TX stayed %0b expected a start bit", tag, TX);
        return;
      end
    end
    step(HALF);
    check({tag, " start bit"}, TX, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(CPB);
      got[i] = TX;
    end
    step(CPB);
    check({tag, " stop bit"}, TX, 1'b1);
    check({tag, " data"}, got, exp);
    $display("tx frame %s %02h", tag, got);
  endtask

  task automatic count_tx_lows(input int cycles, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (TX === 1'b0) lows++;
    end
    check({tag, " TX low cycles"}, lows, 0);
  endtask

  // ---------------- behavioural RX model ----------------
  logic [7:0] m_q[$];
  bit         m_ovr;
  bit         m_ferr;

  function automatic logic [15:0] model_word();
    logic [7:0] head;
    logic       vld;
    vld  = (m_q.size() > 0);
    head = vld ? m_q[0] : 8'h00;
    return {2'b00, 1'b0, m_ferr, m_ovr, 1'b1, 1'b0, vld, head};
  endfunction

  // ---------------- table ----------------
  typedef struct {
    logic [7:0]  b;
    logic        stop;
    logic [15:0] exp_status;
    logic        do_read;
    logic [15:0] exp_after;
  } rx_vec_t;

  rx_vec_t     vecs[6];
  logic [15:0] w;
  logic [7:0]  b;
  logic        sb;
  int          n;
  logic [7:0]  tx_model[$];
  logic [7:0]  lb_q[$];

  initial begin
    vecs[0] = '{8'h3C, 1'b1, 16'h053C, 1'b1, 16'h0400};
    vecs[1] = '{8'hFF, 1'b1, 16'h05FF, 1'b1, 16'h0400};
    vecs[2] = '{8'h00, 1'b0, 16'h1400, 1'b1, 16'h0400};
    vecs[3] = '{8'h81, 1'b1, 16'h0581, 1'b0, 16'h0581};
    vecs[4] = '{8'h7E, 1'b1, 16'h0581, 1'b1, 16'h057E};
    vecs[5] = '{8'h55, 1'b0, 16'h157E, 1'b1, 16'h0400};

    // ---- reset state ----
    do_reset();
    check("reset dataOut", dataOut, 16'h0400);
    check("reset TX", TX, 1'b1);

    // ---- single write held 3 cycles -> one frame of A5 ----
    sel = 1'b1; write = 1'b1; dataIn = 8'hA5;
    step(1);
    check("t1 TX before pop", TX, 1'b1);
    step(1);
    check("t1 start bit latency", TX, 1'b0);
    step(1);
    sel = 1'b0; write = 1'b0;
    step(HALF - 1);
    check("t1 start bit", TX, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(CPB);
      check($sformatf("t1 bit%0d", i), TX, (8'hA5 >> i) & 8'h01);
    end
    step(CPB);
    check("t1 stop bit", TX, 1'b1);
    check("t1 busy txIdle", dataOut[10], 1'b0);
    step(60);
`ifdef UART_LOOPBACK_EN
    check("t1 idle word", dataOut, 16'h05A5);
`else
    check("t1 idle word", dataOut, 16'h0400);
`endif
    count_tx_lows(1200, "t1 single frame");

    // ---- back-to-back writes, overflow, gapless stream ----
    do_reset();
    for (int i = 0; i < 9; i++) cpu_write(8'(i), 1);
    check("t2 txFull after 9", dataOut[9], 1'b1);
    check("t2 no txOvf after 9", dataOut[13], 1'b0);
    for (int i = 9; i < 17; i++) cpu_write(8'(i), 1);
    check("t2 txOvf after 17", dataOut[13], 1'b1);
    expect_tx(8'h00, 1'b0, "t2_0");
    for (int i = 1; i < 9; i++) expect_tx(8'(i), 1'b1, $sformatf("t2_%0d", i));
    step(100);
    check("t2 txIdle at end", dataOut[10], 1'b1);
    check("t2 txOvf sticky", dataOut[13], 1'b1);
`ifndef UART_LOOPBACK_EN
    cpu_read(w);
    check("t2 read word", w, 16'h2400);
    check("t2 txOvf cleared", dataOut, 16'h0400);
`endif

`ifndef UART_LOOPBACK_EN
    // ---- table-driven RX frames ----
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_rx(vecs[i].b, vecs[i].stop);
      step(CPB / 4);
      check($sformatf("vec%0d status", i), dataOut, vecs[i].exp_status);
      if (vecs[i].do_read) begin
        cpu_read(w);
        check($sformatf("vec%0d read", i), w, vecs[i].exp_status);
        check($sformatf("vec%0d after", i), dataOut, vecs[i].exp_after);
      end
    end

    // ---- 30-cycle glitch on idle RX ----
    RX = 1'b0;
    step(30);
    RX = 1'b1;
    step(300);
    check("glitch no frame", dataOut, 16'h0400);

    // ---- RX overrun, then pop+push at full in one cycle ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_rx(8'(8'h10 + i), 1'b1);
      step(20);
    end
    check("t4 overrun word", dataOut, 16'h0D10);
    cpu_read(w);
    check("t4 overrun read", w, 16'h0D10);
    check("t4 ovr cleared", dataOut, 16'h0511);
    send_rx(8'h18, 1'b1);
    step(20);
    check("t4 refilled", dataOut, 16'h0511);
    // Push of 0x19 lands 991 cycles after its start bit is driven: read then.
    fork
      send_rx(8'h19, 1'b1);
      begin
        step(990);
        sel = 1'b1; write = 1'b0;
        w = dataOut;
        step(1);
        sel = 1'b0;
      end
    join
    check("t4 coincident read", w, 16'h0511);
    check("t4 no overrun at pop+push", dataOut, 16'h0512);
    for (int i = 0; i < 8; i++) begin
      cpu_read(w);
      check($sformatf("t4 drain%0d", i), w, 16'h0500 | 16'(8'h12 + i));
    end
    check("t4 drained", dataOut, 16'h0400);

    // ---- randomized RX frames and reads vs queue model ----
    do_reset();
    m_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(9, 0) < 7) begin
        b  = 8'($urandom);
        sb = ($urandom_range(5, 0) != 0);
        send_rx(b, sb);
        step(20);
        if (!sb) m_ferr = 1'b1;
        else if (m_q.size() == 8) m_ovr = 1'b1;
        else m_q.push_back(b);
        check($sformatf("rnd%0d frame status", i), dataOut, model_word());
      end else begin
        cpu_read(w);
        check($sformatf("rnd%0d read", i), w, model_word());
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        check($sformatf("rnd%0d after read", i), dataOut, model_word());
      end
    end
`endif

    // ---- randomized TX bursts vs byte queue ----
    do_reset();
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(3, 1);
      lb_q.delete();
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        tx_model.push_back(b);
        lb_q.push_back(b);
        cpu_write(b, $urandom_range(3, 1));
      end
      for (int j = 0; j < n; j++) begin
        b = tx_model.pop_front();
        expect_tx(b, (j != 0), $sformatf("rtx%0d_%0d", r, j));
      end
      step(100);
`ifdef UART_LOOPBACK_EN
      for (int j = 0; j < n; j++) begin
        cpu_read(w);
        check($sformatf("lb%0d_%0d echo", r, j), w, 16'h0500 | 16'(lb_q[j]));
      end
`endif
      check($sformatf("rtx%0d idle", r), dataOut, 16'h0400);
    end

`ifdef UART_LOOPBACK_EN
    // ---- loopback echo of 5A ----
    do_reset();
    cpu_write(8'h5A, 1);
    expect_tx(8'h5A, 1'b0, "lb5A");
    step(100);
    check("lb 5A received", dataOut, 16'h055A);
`endif

    // ---- reset in the middle of a TX frame ----
    do_reset();
    cpu_write(8'h0F, 1);
    cpu_write(8'h33, 1);
    step(568);
    check("t6 bit4 low", TX, 1'b0);
    RST = 1'b1;
    step(1);
    check("t6 TX high after RST", TX, 1'b1);
    check("t6 dataOut after RST", dataOut, 16'h0400);
    RST = 1'b0;
    step(1);
    count_tx_lows(1200, "t6 fifo flushed");
    check("t6 idle word", dataOut, 16'h0400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
